// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
// level_sequencer : per-level PRELIM/GAME/ANSWER/POST/EVAL sequencer with lives,
// pause, level-scaled tolerance and WON/LOST terminal states.  Rev 1.0
// ============================================================================
module level_sequencer #(
  parameter int PRELIM_SECS = 3,
  parameter int GAME_SECS   = 20,
  parameter int ANSWER_SECS = 3,
  parameter int POST_SECS   = 5,
  parameter int LEVEL_W     = 5,
  parameter int MAX_LEVEL   = 31,
  parameter int DIFF_W      = 7,
  parameter int TOL_BASE    = 3,
  parameter int TOL_SHIFT   = 3,
  parameter int TOL_MIN     = 1,
  parameter int LIVES       = 3
) (
  input  logic                         Clk1Hz,
  input  logic                         reset,
  input  logic                         pause,
  input  logic [DIFF_W-1:0]            symCountDiff,
  output logic [LEVEL_W-1:0]           level,
  output logic                         levelChng,
  output logic                         retry,
  output logic                         prelimPeriod,
  output logic                         gamePeriod,
  output logic                         answerPeriod,
  output logic                         postPeriod,
  output logic [2:0]                   countDownTime,
  output logic [$clog2(LIVES+1)-1:0]   livesLeft,
  output logic                         loss,
  output logic                         win
);

  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int MAX_A   = (PRELIM_SECS > GAME_SECS) ? PRELIM_SECS : GAME_SECS;
  localparam int MAX_B   = (ANSWER_SECS > POST_SECS) ? ANSWER_SECS : POST_SECS;
  localparam int MAX_PH  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_PH + 1);

  typedef enum logic [2:0] {
    S_PRELIM = 3'd0,
    S_GAME   = 3'd1,
    S_ANSWER = 3'd2,
    S_POST   = 3'd3,
    S_EVAL   = 3'd4,
    S_LOST   = 3'd5,
    S_WON    = 3'd6
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_len_m1;
  logic                 w_last;
  logic                 w_timed;
  logic [LEVEL_W-1:0]   w_level_nxt;
  logic [LIVES_W-1:0]   w_lives_nxt;
  logic                 w_lchg_nxt;
  logic                 w_retry_nxt;
  logic [2:0]           w_cdt_nxt;
  logic [31:0]          w_lvl_shift;
  logic [31:0]          w_tol;
  logic                 w_pass;

  // Saturating tolerance: compare before subtracting so it can never wrap.
  assign w_lvl_shift = 32'(level >> TOL_SHIFT);
  assign w_tol       = ((w_lvl_shift + 32'(TOL_MIN)) >= 32'(TOL_BASE)) ? 32'(TOL_MIN)
                                                                       : 32'(TOL_BASE) - w_lvl_shift;
  assign w_pass      = 32'(symCountDiff) < w_tol;
  assign w_cdt_nxt   = 3'(PRELIM_SECS - int'(w_cnt_nxt));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = level;
    w_lives_nxt = livesLeft;
    w_lchg_nxt  = levelChng;
    w_retry_nxt = retry;
    w_len_m1    = '0;
    w_timed     = 1'b1;
    unique case (r_state)
      S_PRELIM: w_len_m1 = CNT_W'(PRELIM_SECS - 1);
      S_GAME:   w_len_m1 = CNT_W'(GAME_SECS - 1);
      S_ANSWER: w_len_m1 = CNT_W'(ANSWER_SECS - 1);
      S_POST:   w_len_m1 = CNT_W'(POST_SECS - 1);
      default:  w_timed  = 1'b0;
    endcase
    w_last = (r_cnt == w_len_m1);

    // While paused every next value equals the current one, so outputs hold.
    if (!pause) begin
      w_lchg_nxt  = 1'b0;
      w_retry_nxt = 1'b0;
      if (w_timed) begin
        w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
      end
      unique case (r_state)
        S_PRELIM: if (w_last) w_state_nxt = S_GAME;
        S_GAME:   if (w_last) w_state_nxt = S_ANSWER;
        S_ANSWER: if (w_last) w_state_nxt = S_POST;
        S_POST:   if (w_last) w_state_nxt = S_EVAL;
        S_EVAL: begin
          if (w_pass) begin
            if (level == LEVEL_W'(MAX_LEVEL - 1)) begin
              w_level_nxt = LEVEL_W'(MAX_LEVEL);
              w_state_nxt = S_WON;
            end else begin
              w_level_nxt = level + 1'b1;
              w_lchg_nxt  = 1'b1;
              w_state_nxt = S_PRELIM;
            end
          end else if (livesLeft > LIVES_W'(1)) begin
            w_lives_nxt = livesLeft - 1'b1;
            w_retry_nxt = 1'b1;
            w_state_nxt = S_PRELIM;
          end else begin
            w_lives_nxt = '0;
            w_state_nxt = S_LOST;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk1Hz) begin
    if (reset) begin
      r_state       <= S_PRELIM;
      r_cnt         <= '0;
      level         <= '0;
      livesLeft     <= LIVES_W'(LIVES);
      levelChng     <= 1'b0;
      retry         <= 1'b0;
      prelimPeriod  <= 1'b1;
      gamePeriod    <= 1'b0;
      answerPeriod  <= 1'b0;
      postPeriod    <= 1'b0;
      countDownTime <= 3'(PRELIM_SECS);
      loss          <= 1'b0;
      win           <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      level         <= w_level_nxt;
      livesLeft     <= w_lives_nxt;
      levelChng     <= w_lchg_nxt;
      retry         <= w_retry_nxt;
      prelimPeriod  <= (w_state_nxt == S_PRELIM);
      gamePeriod    <= (w_state_nxt == S_GAME);
      answerPeriod  <= (w_state_nxt == S_ANSWER);
      postPeriod    <= (w_state_nxt == S_POST);
      countDownTime <= (w_state_nxt == S_PRELIM) ? w_cdt_nxt : 3'd0;
      loss          <= (w_state_nxt == S_LOST);
      win           <= (w_state_nxt == S_WON);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_level_sequencer.sv
`default_nettype none
// ============================================================================
// tb_level_sequencer : scoreboard bench for level_sequencer (default config and
// a 2-level, 1-tick-phase config driven in parallel).  Rev 1.0
// ============================================================================
module tb_level_sequencer;

  typedef struct { int level, lchg, rtry, pre, game, ans, post, cdt, lives, loss, win; } obs_t;
  typedef struct { int pos, level, lives, lost, won, lchg, rtry; } mdl_t;
  typedef struct { int pre, game, ans, post, maxl, tb, ts, tm, lives; } cfg_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pse;
  logic [6:0] diff;

  logic [4:0] a_level;
  logic       a_lchg, a_rtry, a_pre, a_game, a_ans, a_post, a_loss, a_win;
  logic [2:0] a_cdt;
  logic [1:0] a_lives;

  logic [1:0] b_level;
  logic       b_lchg, b_rtry, b_pre, b_game, b_ans, b_post, b_loss, b_win;
  logic [2:0] b_cdt;
  logic [1:0] b_lives;

  int   n_vec = 0;
  int   n_err = 0;
  int   tick_no = 0;
  mdl_t ma, mb;
  cfg_t ca, cb;
  obs_t qa[$];
  obs_t qb[$];

  always #5 clk = ~clk;

  level_sequencer u_dut_a (
    .Clk1Hz(clk), .reset(rst), .pause(pse), .symCountDiff(diff),
    .level(a_level), .levelChng(a_lchg), .retry(a_rtry),
    .prelimPeriod(a_pre), .gamePeriod(a_game), .answerPeriod(a_ans), .postPeriod(a_post),
    .countDownTime(a_cdt), .livesLeft(a_lives), .loss(a_loss), .win(a_win)
  );

  level_sequencer #(
    .PRELIM_SECS(1), .GAME_SECS(1), .ANSWER_SECS(1), .POST_SECS(1),
    .LEVEL_W(2), .MAX_LEVEL(2)
  ) u_dut_b (
    .Clk1Hz(clk), .reset(rst), .pause(pse), .symCountDiff(diff),
    .level(b_level), .levelChng(b_lchg), .retry(b_rtry),
    .prelimPeriod(b_pre), .gamePeriod(b_game), .answerPeriod(b_ans), .postPeriod(b_post),
    .countDownTime(b_cdt), .livesLeft(b_lives), .loss(b_loss), .win(b_win)
  );

  // Reference model: position within the level period decides the phase.
  function automatic mdl_t mstep(mdl_t m, cfg_t c, bit r, bit p, int d);
    mdl_t n = m;
    int   per = c.pre + c.game + c.ans + c.post + 1;
    int   tol;
    if (r) begin
      n.pos = 0; n.level = 0; n.lives = c.lives;
      n.lost = 0; n.won = 0; n.lchg = 0; n.rtry = 0;
    end else if (!p && m.lost == 0 && m.won == 0) begin
      n.lchg = 0; n.rtry = 0;
      if (m.pos == per - 1) begin
        tol = c.tb - m.level / (1 << c.ts);
        if (tol < c.tm) tol = c.tm;
        if (d < tol) begin
          if (m.level == c.maxl - 1) begin
            n.level = c.maxl; n.won = 1;
          end else begin
            n.level = m.level + 1; n.lchg = 1; n.pos = 0;
          end
        end else if (m.lives > 1) begin
          n.lives = m.lives - 1; n.rtry = 1; n.pos = 0;
        end else begin
          n.lives = 0; n.lost = 1;
        end
      end else begin
        n.pos = m.pos + 1;
      end
    end
    return n;
  endfunction

  function automatic obs_t mexp(mdl_t m, cfg_t c);
    obs_t o = '{default: 0};
    o.level = m.level; o.lchg = m.lchg; o.rtry = m.rtry;
    o.lives = m.lives; o.loss = m.lost; o.win = m.won;
    if (m.lost == 0 && m.won == 0) begin
      if (m.pos < c.pre) begin
        o.pre = 1; o.cdt = c.pre - m.pos;
      end else if (m.pos < c.pre + c.game) o.game = 1;
      else if (m.pos < c.pre + c.game + c.ans) o.ans = 1;
      else if (m.pos < c.pre + c.game + c.ans + c.post) o.post = 1;
    end
    return o;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.level = int'(a_level); o.lchg = int'(a_lchg); o.rtry = int'(a_rtry);
    o.pre = int'(a_pre); o.game = int'(a_game); o.ans = int'(a_ans); o.post = int'(a_post);
    o.cdt = int'(a_cdt); o.lives = int'(a_lives); o.loss = int'(a_loss); o.win = int'(a_win);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.level = int'(b_level); o.lchg = int'(b_lchg); o.rtry = int'(b_rtry);
    o.pre = int'(b_pre); o.game = int'(b_game); o.ans = int'(b_ans); o.post = int'(b_post);
    o.cdt = int'(b_cdt); o.lives = int'(b_lives); o.loss = int'(b_loss); o.win = int'(b_win);
    return o;
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp(string who, obs_t e, obs_t g);
    chk($sformatf("%s.level@t%0d", who, tick_no), g.level, e.level);
    chk($sformatf("%s.levelChng@t%0d", who, tick_no), g.lchg, e.lchg);
    chk($sformatf("%s.retry@t%0d", who, tick_no), g.rtry, e.rtry);
    chk($sformatf("%s.prelim@t%0d", who, tick_no), g.pre, e.pre);
    chk($sformatf("%s.game@t%0d", who, tick_no), g.game, e.game);
    chk($sformatf("%s.answer@t%0d", who, tick_no), g.ans, e.ans);
    chk($sformatf("%s.post@t%0d", who, tick_no), g.post, e.post);
    chk($sformatf("%s.countDown@t%0d", who, tick_no), g.cdt, e.cdt);
    chk($sformatf("%s.livesLeft@t%0d", who, tick_no), g.lives, e.lives);
    chk($sformatf("%s.loss@t%0d", who, tick_no), g.loss, e.loss);
    chk($sformatf("%s.win@t%0d", who, tick_no), g.win, e.win);
  endtask

  task automatic tick(bit r, bit p, int d);
    rst  = r;
    pse  = p;
    diff = 7'(d);
    ma = mstep(ma, ca, r, p, d);
    mb = mstep(mb, cb, r, p, d);
    qa.push_back(mexp(ma, ca));
    qb.push_back(mexp(mb, cb));
    @(posedge clk);
    #1;
    tick_no = r ? 0 : tick_no + 1;
    cmp("A", qa.pop_front(), obs_a());
    cmp("B", qb.pop_front(), obs_b());
  endtask

  task automatic run(int n, bit p, int d);
    for (int i = 0; i < n; i++) tick(1'b0, p, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ca = '{3, 20, 3, 5, 31, 3, 3, 1, 3};
    cb = '{1, 1, 1, 1, 2, 3, 3, 1, 3};
    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1'b1; pse = 1'b0; diff = '0;

    // Always-pass run: schedule, level advance, B reaches WON
    tick(1'b1, 1'b0, 0);
    chk("rst_cdt", int'(a_cdt), 3);
    run(10, 1'b0, 0);
    chk("B_win_t10", int'(b_win), 1);
    chk("B_level_t10", int'(b_level), 2);
    chk("B_lchg_t10", int'(b_lchg), 0);
    run(22, 1'b0, 0);
    chk("A_level_t32", int'(a_level), 1);
    chk("A_lchg_t32", int'(a_lchg), 1);
    run(1, 1'b0, 0);
    chk("A_lchg_t33", int'(a_lchg), 0);
    run(223, 1'b0, 0);
    chk("A_level8", int'(a_level), 8);

    // Level 8 tolerance 2, level 24 tolerance 1
    run(32, 1'b0, 2);
    chk("L8_fail_retry", int'(a_rtry), 1);
    run(32, 1'b0, 1);
    chk("L8_pass_level", int'(a_level), 9);
    run(480, 1'b0, 0);
    run(32, 1'b0, 1);
    chk("L24_fail_retry", int'(a_rtry), 1);
    run(32, 1'b0, 0);
    chk("L24_pass_level", int'(a_level), 25);

    // Three fails -> LOST, frozen, then reset with pause high
    tick(1'b1, 1'b0, 0);
    run(96, 1'b0, 3);
    chk("loss_t96", int'(a_loss), 1);
    chk("lives_t96", int'(a_lives), 0);
    run(12, 1'b0, 0);
    tick(1'b1, 1'b1, 0);
    chk("lost_rst_loss", int'(a_loss), 0);
    chk("lost_rst_lives", int'(a_lives), 3);

    // Pause for 5 ticks in GAME
    run(10, 1'b0, 0);
    run(5, 1'b1, 0);
    run(12, 1'b0, 0);
    chk("pause_game_t27", int'(a_game), 1);
    run(9, 1'b0, 0);
    chk("pause_eval_t36", int'({a_pre, a_game, a_ans, a_post}), 0);

    // Reset during POST with pause high
    run(28, 1'b0, 0);
    run(2, 1'b1, 0);
    tick(1'b1, 1'b1, 0);
    chk("post_rst_level", int'(a_level), 0);
    chk("post_rst_prelim", int'(a_pre), 1);
    run(4, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/level_sequencer.md
# level_sequencer

Parametrised game-level sequencer for the symbol-counting game, driven by the 1 Hz game tick. Each level runs prelim (countdown), game, answer and post phases of configurable length, then one evaluation second that grades the player's count error. A pass advances the level. A fail costs a life and retries the same level. Tolerance tightens as the level rises. The block adds pause, lives, a win terminal state and level-scaled tolerance.

## Interface
Parameters:
- PRELIM_SECS, 3, prelim/countdown length in ticks (1..7)
- GAME_SECS, 20, game phase length (≥1)
- ANSWER_SECS, 3, answer phase length (≥1)
- POST_SECS, 5, post phase length (≥1)
- LEVEL_W, 5, level counter width
- MAX_LEVEL, 31, number of levels; must satisfy MAX_LEVEL < 2^LEVEL_W
- DIFF_W, 7, width of symCountDiff
- TOL_BASE, 3, tolerance at level 0
- TOL_SHIFT, 3, tolerance drops by 1 every 2^TOL_SHIFT levels
- TOL_MIN, 1, tolerance floor (≥1)
- LIVES, 3, attempts before loss (≥1)

Ports:
- Clk1Hz  in  1  game tick clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- pause  in  1  freezes all state while high
- symCountDiff  in  DIFF_W  unsigned absolute count error; sampled only in EVAL
- level  out  LEVEL_W  current level, 0-based
- levelChng  out  1  one-tick pulse on the first PRELIM tick after a pass
- retry  out  1  one-tick pulse on the first PRELIM tick after a fail that still has lives left
- prelimPeriod, gamePeriod, answerPeriod, postPeriod  out  1 each  phase flags, one-hot or all 0
- countDownTime  out  3  PRELIM_SECS − phaseCnt during PRELIM, else 0
- livesLeft  out  clog2(LIVES+1)  remaining lives
- loss  out  1  held high in LOST
- win  out  1  held high in WON

## Operation
- States: PRELIM, GAME, ANSWER, POST, EVAL, LOST, WON. phaseCnt counts ticks within a phase and is sized for max(phase lengths).
- Reset sets state=PRELIM, phaseCnt=0, level=0, livesLeft=LIVES, and clears levelChng/retry. The phase flags then show prelimPeriod=1, others 0. countDownTime=PRELIM_SECS, loss=0, win=0.
- Each timed phase of length N lasts exactly N ticks:
  - phaseCnt runs 0..N−1.
  - At N−1 the state advances to the next phase and phaseCnt returns to 0.
  - Phase order: PRELIM→GAME→ANSWER→POST→EVAL.
- Tolerance: tol = max(TOL_BASE − (level >> TOL_SHIFT), TOL_MIN), computed as unsigned with saturation at TOL_MIN and no underflow.
- EVAL lasts 1 tick. Pass iff symCountDiff < tol. On the EVAL edge:
  - pass, level < MAX_LEVEL−1: level+1, levelChng←1, go to PRELIM
  - pass, level = MAX_LEVEL−1: level←MAX_LEVEL, go to WON
  - fail, livesLeft > 1: livesLeft−1, retry←1, level unchanged, go to PRELIM
  - fail, livesLeft = 1: livesLeft←0, go to LOST
- levelChng and retry are high only for the first PRELIM tick and clear on the following edge.
- LOST and WON are terminal. All outputs hold, phase flags are 0, countDownTime=0. Only reset exits.
- pause=1: state, phaseCnt, level and livesLeft hold, and outputs hold their values. A pending levelChng/retry pulse stays high until the first unpaused edge.
- Reset asserted together with pause, or in any state including EVAL/LOST/WON, gives the reset values on the next edge.
- All outputs are Moore, decoded from registered state, so there are no combinational paths from inputs to outputs.

## Timing
- Level period = PRELIM+GAME+ANSWER+POST+1 ticks, which is 32 ticks at the defaults.
- Tick numbering: tick t is the t-th edge after reset is released; tick 0 is PRELIM with phaseCnt=0.
- Default schedule:
  - ticks 0–2: PRELIM, countDownTime 3,2,1
  - ticks 3–22: GAME
  - ticks 23–25: ANSWER
  - ticks 26–30: POST
  - tick 31: EVAL
  - tick 32: PRELIM with the new level, levelChng or retry high
- symCountDiff setup applies to the edge that ends the EVAL tick. Its value at any other tick is ignored.
- Each paused tick extends the current phase by exactly one tick.

## Test plan
- Defaults, reset then symCountDiff=0 throughout:
  - flags follow the 3/20/3/5/1 schedule, countDownTime 3,2,1
  - tick 32: level=1, levelChng=1; tick 33: levelChng=0
- symCountDiff=3 at level 0 (tol 3) → tick 32: retry=1, livesLeft=2, level=0. Two more fails → loss=1 at tick 96, livesLeft=0, flags 0, state frozen for 10+ ticks.
- Tolerance scaling:
  - level 8 (tol 2): diff=2 fails, diff=1 passes
  - level 24: tol = max(3−3, 1) = 1, so diff=0 passes and diff=1 fails
- pause high for 5 ticks starting at tick 10 (GAME) → GAME ends at tick 27, EVAL at tick 36, outputs constant while paused.
- MAX_LEVEL=2, all 1-tick phases, diff=0 → two passes → win=1, level=2, flags 0, levelChng not pulsed on the final pass.
- reset asserted during POST with pause=1, and again during LOST → next edge: PRELIM, level=0, livesLeft=LIVES, countDownTime=PRELIM_SECS, loss=win=levelChng=retry=0.
